// File: rtl/usb_rx_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : usb_rx_sequencer
// Purpose  : Packet-level receive sequencer for a USB full-speed receiver.
//            Tracks SYNC, PID, payload bytes and end-of-packet. Writes
//            payload bytes to a downstream FIFO and flags malformed packets.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk          in   system clock, rising edge
//   n_rst        in   synchronous active-low reset
//   d_edge       in   pulse, bus transition detected (starts a packet)
//   eop          in   level, end-of-packet on bus
//   one_byte     in   pulse, shift register completed 8 bits
//   rcv_data     in   [15:0] shift register, newest byte in [15:8]
//   buffer_full  in   downstream FIFO cannot accept a write
//   clear        out  resets shift-register bit counters
//   rcving       out  packet reception in progress
//   w_enable     out  one-cycle FIFO write strobe
//   rx_data      out  [7:0] byte presented with w_enable
//   rx_packet    out  [3:0] decoded PID
//   r_error      out  packet error flag, sticky until next packet start
// ============================================================================
module usb_rx_sequencer #(
  parameter int MAX_BYTES = 66
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        d_edge,
  input  logic        eop,
  input  logic        one_byte,
  input  logic [15:0] rcv_data,
  input  logic        buffer_full,
  output logic        clear,
  output logic        rcving,
  output logic        w_enable,
  output logic [7:0]  rx_data,
  output logic [3:0]  rx_packet,
  output logic        r_error
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SYNC     = 3'd1,
    PID      = 3'd2,
    DATA     = 3'd3,
    TOKEN    = 3'd4,
    HSHAKE   = 3'd5,
    EOP_WAIT = 3'd6,
    ERR_WAIT = 3'd7
  } state_t;

  localparam logic [6:0] C_MAX_BYTES = 7'(MAX_BYTES);
  localparam logic [7:0] C_SYNC_BYTE = 8'h80;

  state_t      r_state, w_state_next;
  logic [6:0]  r_count, w_count_next;
  logic        r_eop_seen, w_eop_seen_next;
  logic        r_clear, w_clear_next;
  logic        r_rcving, w_rcving_next;
  logic        r_wen, w_wen_next;
  logic [7:0]  r_rx_data, w_rx_data_next;
  logic [3:0]  r_rx_packet, w_rx_packet_next;
  logic        r_err, w_err_next;

  logic [3:0]  w_pid;
  logic        w_pid_ok;
  logic        w_unused;

  assign w_pid    = rcv_data[11:8];
  assign w_pid_ok = (rcv_data[11:8] == ~rcv_data[15:12]);
  // Only the newest byte matters at packet level.
  assign w_unused = ^rcv_data[7:0];

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      r_state     <= IDLE;
      r_count     <= '0;
      r_eop_seen  <= 1'b0;
      r_clear     <= 1'b0;
      r_rcving    <= 1'b0;
      r_wen       <= 1'b0;
      r_rx_data   <= '0;
      r_rx_packet <= '0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_count     <= w_count_next;
      r_eop_seen  <= w_eop_seen_next;
      r_clear     <= w_clear_next;
      r_rcving    <= w_rcving_next;
      r_wen       <= w_wen_next;
      r_rx_data   <= w_rx_data_next;
      r_rx_packet <= w_rx_packet_next;
      r_err       <= w_err_next;
    end
  end

  always_comb begin
    w_state_next     = r_state;
    w_count_next     = r_count;
    w_clear_next     = 1'b0;
    w_rcving_next    = r_rcving;
    w_wen_next       = 1'b0;
    w_rx_data_next   = r_rx_data;
    w_rx_packet_next = r_rx_packet;
    w_err_next       = r_err;
    // ERR_WAIT may only exit after eop has been high. An entry caused by eop
    // itself captures that here; a byte-caused entry has eop low.
    w_eop_seen_next  = (r_state == ERR_WAIT) ? (r_eop_seen | eop) : eop;

    case (r_state)
      IDLE: begin
        if (d_edge) begin
          w_state_next     = SYNC;
          w_clear_next     = 1'b1;
          w_rcving_next    = 1'b1;
          w_err_next       = 1'b0;
          w_rx_packet_next = '0;
          w_count_next     = '0;
        end
      end
      SYNC: begin
        if (eop) begin
          w_state_next = ERR_WAIT;
          w_err_next   = 1'b1;
        end else if (one_byte) begin
          w_clear_next = 1'b1;
          if (rcv_data[15:8] == C_SYNC_BYTE) begin
            w_state_next = PID;
          end else begin
            w_state_next = ERR_WAIT;
            w_err_next   = 1'b1;
          end
        end
      end
      PID: begin
        if (eop) begin
          w_state_next = ERR_WAIT;
          w_err_next   = 1'b1;
        end else if (one_byte) begin
          w_state_next = ERR_WAIT;
          w_err_next   = 1'b1;
          if (w_pid_ok) begin
            case (w_pid)
              4'b0001, 4'b1001: begin
                w_state_next     = TOKEN;
                w_err_next       = 1'b0;
                w_rx_packet_next = w_pid;
              end
              4'b0011, 4'b1011: begin
                w_state_next     = DATA;
                w_err_next       = 1'b0;
                w_rx_packet_next = w_pid;
              end
              4'b0010, 4'b1010: begin
                w_state_next     = HSHAKE;
                w_err_next       = 1'b0;
                w_rx_packet_next = w_pid;
              end
              default: ;
            endcase
          end
        end
      end
      DATA: begin
        // eop is checked first so a coincident byte is dropped.
        if (eop) begin
          if (r_count >= 7'd2) begin
            w_state_next = EOP_WAIT;
          end else begin
            w_state_next = ERR_WAIT;
            w_err_next   = 1'b1;
          end
        end else if (one_byte) begin
          if (buffer_full || (r_count >= C_MAX_BYTES)) begin
            w_state_next = ERR_WAIT;
            w_err_next   = 1'b1;
          end else begin
            w_wen_next     = 1'b1;
            w_rx_data_next = rcv_data[15:8];
            if (r_count != 7'h7F) begin
              w_count_next = r_count + 7'd1;
            end
          end
        end
      end
      TOKEN: begin
        if (eop) begin
          if (r_count == 7'd2) begin
            w_state_next = EOP_WAIT;
          end else begin
            w_state_next = ERR_WAIT;
            w_err_next   = 1'b1;
          end
        end else if (one_byte) begin
          if (r_count >= 7'd2) begin
            w_state_next = ERR_WAIT;
            w_err_next   = 1'b1;
          end else begin
            w_count_next = r_count + 7'd1;
          end
        end
      end
      HSHAKE: begin
        if (eop) begin
          w_state_next = EOP_WAIT;
        end else if (one_byte) begin
          w_state_next = ERR_WAIT;
          w_err_next   = 1'b1;
        end
      end
      EOP_WAIT: begin
        if (!eop) begin
          w_state_next  = IDLE;
          w_rcving_next = 1'b0;
        end
      end
      ERR_WAIT: begin
        if (!eop && r_eop_seen) begin
          w_state_next  = IDLE;
          w_rcving_next = 1'b0;
        end
      end
      default: begin
        w_state_next  = IDLE;
        w_rcving_next = 1'b0;
      end
    endcase
  end

  assign clear     = r_clear;
  assign rcving    = r_rcving;
  assign w_enable  = r_wen;
  assign rx_data   = r_rx_data;
  assign rx_packet = r_rx_packet;
  assign r_error   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_usb_rx_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_usb_rx_sequencer
// Purpose  : Self-checking bench for usb_rx_sequencer. Payload bytes that
//            must reach the FIFO are queued as they are driven and matched
//            against every w_enable strobe.
// Revision : 1.0 - initial release
// ============================================================================
module tb_usb_rx_sequencer;

  logic        clk;
  logic        n_rst;
  logic        d_edge;
  logic        eop;
  logic        one_byte;
  logic [15:0] rcv_data;
  logic        buffer_full;
  logic        clear;
  logic        rcving;
  logic        w_enable;
  logic [7:0]  rx_data;
  logic [3:0]  rx_packet;
  logic        r_error;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          n_writes = 0;
  logic [7:0]  exp_q[$];
  logic        prev_wen = 1'b0;

  usb_rx_sequencer #(.MAX_BYTES(66)) dut (
    .clk         (clk),
    .n_rst       (n_rst),
    .d_edge      (d_edge),
    .eop         (eop),
    .one_byte    (one_byte),
    .rcv_data    (rcv_data),
    .buffer_full (buffer_full),
    .clear       (clear),
    .rcving      (rcving),
    .w_enable    (w_enable),
    .rx_data     (rx_data),
    .rx_packet   (rx_packet),
    .r_error     (r_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard: every write strobe must match the oldest expected byte.
  always @(negedge clk) begin
    if (n_rst && w_enable) begin
      n_writes++;
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_write: got rx_data=%h, expected no write", rx_data);
      end else begin
        logic [7:0] exp_b;
        exp_b = exp_q.pop_front();
        if (rx_data !== exp_b) begin
          n_fail++;
          $display("FAIL write_data: got %h, expected %h", rx_data, exp_b);
        end
      end
      n_checks++;
      if (prev_wen !== 1'b0 || rcving !== 1'b1) begin
        n_fail++;
        $display("FAIL write_framing: prev_wen=%b rcving=%b, expected 0/1", prev_wen, rcving);
      end
    end
    prev_wen = w_enable;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic start_pkt();
    d_edge = 1'b1;
    cyc(1);
    d_edge = 1'b0;
    cyc(2);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit expect_write);
    rcv_data = {b, rcv_data[15:8]};
    if (expect_write) exp_q.push_back(b);
    one_byte = 1'b1;
    cyc(1);
    one_byte = 1'b0;
    cyc(2);
  endtask

  task automatic end_pkt();
    eop = 1'b1;
    cyc(2);
    eop = 1'b0;
    cyc(2);
  endtask

  task automatic test_reset();
    n_checks++;
    if ({clear, rcving, w_enable, rx_data, rx_packet, r_error} !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h, expected 0",
               {clear, rcving, w_enable, rx_data, rx_packet, r_error});
    end
  endtask

  task automatic test_data0();
    int w0;
    w0 = n_writes;
    d_edge = 1'b1;
    cyc(1);
    d_edge = 1'b0;
    n_checks++;
    if (clear !== 1'b1 || rcving !== 1'b1) begin
      n_fail++;
      $display("FAIL start_clear: clear=%b rcving=%b, expected 1/1", clear, rcving);
    end
    cyc(1);
    n_checks++;
    if (clear !== 1'b0) begin
      n_fail++;
      $display("FAIL clear_pulse: clear=%b, expected 0", clear);
    end
    cyc(1);
    send_byte(8'h80, 0);
    send_byte(8'hC3, 0);
    n_checks++;
    if (rx_packet !== 4'b0011) begin
      n_fail++;
      $display("FAIL data0_pid: got %b, expected 0011", rx_packet);
    end
    send_byte(8'h11, 1);
    d_edge = 1'b1;  // must be ignored outside IDLE
    cyc(1);
    d_edge = 1'b0;
    send_byte(8'h22, 1);
    send_byte(8'hAA, 1);
    send_byte(8'hBB, 1);
    end_pkt();
    n_checks++;
    if (n_writes - w0 !== 4 || exp_q.size() !== 0) begin
      n_fail++;
      $display("FAIL data0_writes: got %0d writes (%0d pending), expected 4", n_writes - w0, exp_q.size());
    end
    n_checks++;
    if (r_error !== 1'b0 || rcving !== 1'b0 || rx_packet !== 4'b0011) begin
      n_fail++;
      $display("FAIL data0_end: err=%b rcving=%b pid=%b, expected 0/0/0011", r_error, rcving, rx_packet);
    end
  endtask

  task automatic test_bad_sync();
    int w0;
    w0 = n_writes;
    start_pkt();
    send_byte(8'h81, 0);
    send_byte(8'hC3, 0);
    send_byte(8'h11, 0);
    n_checks++;
    if (r_error !== 1'b1 || rcving !== 1'b1) begin
      n_fail++;
      $display("FAIL bad_sync_err: err=%b rcving=%b, expected 1/1", r_error, rcving);
    end
    end_pkt();
    n_checks++;
    if (r_error !== 1'b1 || rcving !== 1'b0 || n_writes != w0) begin
      n_fail++;
      $display("FAIL bad_sync_end: err=%b rcving=%b writes=%0d, expected 1/0/0", r_error, rcving, n_writes - w0);
    end
    start_pkt();
    n_checks++;
    if (r_error !== 1'b0) begin
      n_fail++;
      $display("FAIL err_cleared: err=%b, expected 0", r_error);
    end
    send_byte(8'h80, 0);
    send_byte(8'hC3, 0);
    send_byte(8'h5A, 1);
    send_byte(8'hA5, 1);
    end_pkt();
    n_checks++;
    if (r_error !== 1'b0 || exp_q.size() !== 0) begin
      n_fail++;
      $display("FAIL recovery_pkt: err=%b pending=%0d, expected 0/0", r_error, exp_q.size());
    end
  endtask

  task automatic test_token();
    for (int nb = 2; nb <= 3; nb++) begin
      int w0;
      w0 = n_writes;
      start_pkt();
      send_byte(8'h80, 0);
      send_byte(8'hE1, 0);
      for (int i = 0; i < nb; i++) send_byte(8'h30 + 8'(i), 0);
      end_pkt();
      n_checks++;
      if (rx_packet !== 4'b0001 || n_writes != w0 || r_error !== (nb == 3)) begin
        n_fail++;
        $display("FAIL token_%0d: pid=%b writes=%0d err=%b, expected 0001/0/%0d",
                 nb, rx_packet, n_writes - w0, r_error, nb == 3);
      end
    end
  endtask

  task automatic test_bad_pid();
    logic [7:0] pids[2];
    pids[0] = 8'hC4;
    pids[1] = 8'hF0;
    for (int k = 0; k < 2; k++) begin
      int w0;
      w0 = n_writes;
      start_pkt();
      send_byte(8'h80, 0);
      send_byte(pids[k], 0);
      send_byte(8'h12, 0);
      end_pkt();
      n_checks++;
      if (r_error !== 1'b1 || n_writes != w0 || rcving !== 1'b0) begin
        n_fail++;
        $display("FAIL bad_pid_%h: err=%b writes=%0d rcving=%b, expected 1/0/0",
                 pids[k], r_error, n_writes - w0, rcving);
      end
    end
  endtask

  task automatic test_hshake();
    start_pkt();
    send_byte(8'h80, 0);
    send_byte(8'hD2, 0);
    end_pkt();
    n_checks++;
    if (r_error !== 1'b0 || rx_packet !== 4'b0010) begin
      n_fail++;
      $display("FAIL ack: err=%b pid=%b, expected 0/0010", r_error, rx_packet);
    end
    start_pkt();
    send_byte(8'h80, 0);
    send_byte(8'h5A, 0);
    send_byte(8'h01, 0);
    end_pkt();
    n_checks++;
    if (r_error !== 1'b1 || rx_packet !== 4'b1010) begin
      n_fail++;
      $display("FAIL nak_extra: err=%b pid=%b, expected 1/1010", r_error, rx_packet);
    end
  endtask

  task automatic test_buffer_full();
    int w0;
    w0 = n_writes;
    start_pkt();
    send_byte(8'h80, 0);
    send_byte(8'h4B, 0);
    send_byte(8'h01, 1);
    send_byte(8'h02, 1);
    buffer_full = 1'b1;
    send_byte(8'h03, 0);
    buffer_full = 1'b0;
    send_byte(8'h04, 0);
    end_pkt();
    n_checks++;
    if (n_writes - w0 !== 2 || r_error !== 1'b1 || rx_packet !== 4'b1011) begin
      n_fail++;
      $display("FAIL buffer_full: writes=%0d err=%b pid=%b, expected 2/1/1011",
               n_writes - w0, r_error, rx_packet);
    end
  endtask

  task automatic test_max_bytes();
    int w0;
    w0 = n_writes;
    start_pkt();
    send_byte(8'h80, 0);
    send_byte(8'hC3, 0);
    for (int i = 0; i < 67; i++) send_byte(8'(i + 1), i < 66);
    end_pkt();
    n_checks++;
    if (n_writes - w0 !== 66 || r_error !== 1'b1 || exp_q.size() !== 0) begin
      n_fail++;
      $display("FAIL max_bytes: writes=%0d err=%b pending=%0d, expected 66/1/0",
               n_writes - w0, r_error, exp_q.size());
    end
  endtask

  task automatic test_boundary();
    int w0;
    start_pkt();
    send_byte(8'h80, 0);
    send_byte(8'hC3, 0);
    send_byte(8'h66, 1);
    end_pkt();
    n_checks++;
    if (r_error !== 1'b1) begin
      n_fail++;
      $display("FAIL short_data: err=%b, expected 1", r_error);
    end
    w0 = n_writes;
    start_pkt();
    send_byte(8'h80, 0);
    send_byte(8'hC3, 0);
    send_byte(8'h21, 1);
    send_byte(8'h43, 1);
    rcv_data = {8'h77, rcv_data[15:8]};
    one_byte = 1'b1;
    eop = 1'b1;
    cyc(1);
    one_byte = 1'b0;
    cyc(1);
    eop = 1'b0;
    cyc(3);
    n_checks++;
    if (n_writes - w0 !== 2 || r_error !== 1'b0 || rcving !== 1'b0) begin
      n_fail++;
      $display("FAIL eop_priority: writes=%0d err=%b rcving=%b, expected 2/0/0",
               n_writes - w0, r_error, rcving);
    end
  endtask

  task automatic test_reset_mid_packet();
    int w0;
    w0 = n_writes;
    start_pkt();
    send_byte(8'h80, 0);
    send_byte(8'hC3, 0);
    send_byte(8'h33, 1);
    send_byte(8'h44, 1);
    n_rst = 1'b0;
    cyc(1);
    n_checks++;
    if ({clear, rcving, w_enable, rx_data, rx_packet, r_error} !== 16'h0) begin
      n_fail++;
      $display("FAIL mid_reset: got %h, expected 0",
               {clear, rcving, w_enable, rx_data, rx_packet, r_error});
    end
    n_rst = 1'b1;
    cyc(3);
    n_checks++;
    if (n_writes - w0 !== 2 || exp_q.size() !== 0 || rcving !== 1'b0) begin
      n_fail++;
      $display("FAIL after_reset: writes=%0d pending=%0d rcving=%b, expected 2/0/0",
               n_writes - w0, exp_q.size(), rcving);
    end
    w0 = n_writes;
    start_pkt();
    send_byte(8'h80, 0);
    send_byte(8'hC3, 0);
    send_byte(8'h55, 1);
    send_byte(8'h56, 1);
    end_pkt();
    n_checks++;
    if (n_writes - w0 !== 2 || r_error !== 1'b0 || rx_packet !== 4'b0011) begin
      n_fail++;
      $display("FAIL post_reset_pkt: writes=%0d err=%b pid=%b, expected 2/0/0011",
               n_writes - w0, r_error, rx_packet);
    end
  endtask

  initial begin
    n_rst       = 1'b0;
    d_edge      = 1'b0;
    eop         = 1'b0;
    one_byte    = 1'b0;
    rcv_data    = 16'h0;
    buffer_full = 1'b0;
    cyc(3);
    test_reset();
    n_rst = 1'b1;
    cyc(2);
    test_data0();
    test_bad_sync();
    test_token();
    test_bad_pid();
    test_hshake();
    test_buffer_full();
    test_max_bytes();
    test_boundary();
    test_reset_mid_packet();
    cyc(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
